// File: rtl/dpram_pkg.sv
// Shared definitions for the 16x8 dual-port RAM and its port-B stream reader.
// Holds the default geometry, read latency and the reader FSM encoding.
package dpram_pkg;

    localparam int DP_DATA_WIDTH    = 8;
    localparam int DP_ADDRESS_WIDTH = 4;
    localparam int DP_DEPTH         = 1 << DP_ADDRESS_WIDTH;
    localparam int RD_LATENCY       = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dpram_stream_reader_skid.sv
// stream_skid2: two-entry FIFO feeding a valid/ready stream.
// Ports: push_i/data_i/last_i in, pop_i, count_o, valid_o/data_o/last_o out.
module stream_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o
);

    logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
    logic         l0_q, l0_d, l1_q, l1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign pop = pop_i && (cnt_q != 2'd0);

    // Entry 0 is always the head; entry 1 only holds the skid word.
    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        cnt_d = cnt_q;
        unique case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    d0_d  = data_i;
                    l0_d  = last_i;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop) begin
                    d0_d = data_i;
                    l0_d = last_i;
                end else if (push_i) begin
                    d1_d  = data_i;
                    l1_d  = last_i;
                    cnt_d = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    d0_d = d1_q;
                    l0_d = l1_q;
                    if (push_i) begin
                        d1_d = data_i;
                        l1_d = last_i;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q  <= '0;
            d1_q  <= '0;
            l0_q  <= 1'b0;
            l1_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            l0_q  <= l0_d;
            l1_q  <= l1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = d0_q;
    assign last_o  = valid_o && l0_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Port-B read engine: sequential wrapping reads streamed out valid/ready.
// Ports: start/base_addr/length cmd, busy/done, RAM port B, out_* stream.
module dpram_stream_reader
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH    = DP_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DP_ADDRESS_WIDTH,
    parameter int DEPTH         = DP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_addr_b,
    output logic                     ram_we_b,
    input  logic [DATA_WIDTH-1:0]    ram_dout_b,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam logic [ADDRESS_WIDTH:0]   C_ONE = 1;
    localparam logic [ADDRESS_WIDTH-1:0] A_ONE = 1;

    rd_state_e                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   len_q, len_d;
    logic [ADDRESS_WIDTH:0]   issued_q, issued_d;
    logic [ADDRESS_WIDTH:0]   pushed_q, pushed_d;
    logic                     inflight_q, inflight_d;
    logic                     done_q, done_d;

    logic [1:0] fifo_cnt;
    logic       pop;
    logic       push_last;
    logic [2:0] occ;
    logic       issue;

    // addr_q is the RAM's address register: data for it appears on
    // ram_dout_b during the following cycle and is pushed at the next edge.
    assign pop       = out_valid && out_ready;
    assign push_last = (pushed_q + C_ONE) == len_q;

    // A pop at this edge frees a slot for the word arriving next edge,
    // which keeps one beat per cycle while the FIFO never exceeds 2.
    assign occ   = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (state_q == READ) && (issued_q != len_q)
                   && (occ < 3'd2);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        pushed_d   = inflight_q ? pushed_q + C_ONE : pushed_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = READ;
                        addr_d     = base_addr;
                        len_d      = length;
                        issued_d   = C_ONE;
                        pushed_d   = '0;
                        inflight_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d     = addr_q + A_ONE;
                    issued_d   = issued_q + C_ONE;
                    inflight_d = 1'b1;
                end
                if (issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            pushed_q   <= pushed_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    stream_skid2 #(
        .W (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  (ram_dout_b),
        .last_i  (push_last),
        .pop_i   (pop),
        .count_o (fifo_cnt),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last)
    );

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign ram_addr_b = addr_q;
    assign ram_we_b   = 1'b0;

endmodule
